// File: rtl/dice_result_capture.sv
`default_nettype none
// ============================================================================
// Module   : dice_result_capture
// Brief    : Watches the dice button/throw bus, captures the settled face and
//            keeps score, roll count, doubles and bad-face status.
//            Optional macro DICE_HIST_EN builds per-face histogram counters.
// Revision : 1.0 - initial release
// ============================================================================
module dice_result_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [2:0]         throw,
    output logic [2:0]         result,
    output logic               result_valid,
    output logic               rolling,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         roll_count,
    output logic               double_flag,
    output logic               bad_throw,
    input  logic [2:0]         hist_sel,
    output logic [7:0]         hist_count
);

    localparam int c_CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ROLLING = 2'd1;
    localparam logic [1:0] c_ST_SETTLE  = 2'd2;
    localparam logic [1:0] c_ST_CAPTURE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         r_shadow;
    logic [2:0]         w_shadow_nxt;
    logic               w_capture;
    logic               w_face_ok;
    logic [SCORE_W:0]   w_sum;

    logic [2:0]         r_result;
    logic               r_result_valid;
    logic               r_rolling;
    logic [SCORE_W-1:0] r_score;
    logic [7:0]         r_roll_count;
    logic               r_double;
    logic               r_bad;
    logic               r_have_prev;
    logic [7:0]         w_hist;

    // w_capture marks the edge that enters CAPTURE, so the captured values
    // are already visible during the single CAPTURE cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_capture    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (button) begin
                    w_state_nxt = c_ST_ROLLING;
                end
            end
            c_ST_ROLLING: begin
                if (!button) begin
                    w_state_nxt  = c_ST_SETTLE;
                    w_cnt_nxt    = '0;
                    w_shadow_nxt = throw;
                end
            end
            c_ST_SETTLE: begin
                if (button) begin
                    w_state_nxt = c_ST_ROLLING;
                end else if (throw != r_shadow) begin
                    w_shadow_nxt = throw;
                    w_cnt_nxt    = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_CAPTURE;
                    w_capture   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_CAPTURE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign w_face_ok = (r_shadow != 3'd0) && (r_shadow != 3'd7);
    // One extra bit holds the carry used for saturation.
    assign w_sum     = {1'b0, r_score} + {{(SCORE_W-2){1'b0}}, r_shadow};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= c_ST_IDLE;
            r_cnt          <= '0;
            r_shadow       <= 3'd0;
            r_result       <= 3'd0;
            r_result_valid <= 1'b0;
            r_rolling      <= 1'b0;
            r_score        <= '0;
            r_roll_count   <= 8'd0;
            r_double       <= 1'b0;
            r_bad          <= 1'b0;
            r_have_prev    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_shadow       <= w_shadow_nxt;
            r_rolling      <= (w_state_nxt == c_ST_ROLLING) || (w_state_nxt == c_ST_SETTLE);
            r_result_valid <= w_capture && w_face_ok;
            r_double       <= w_capture && w_face_ok && r_have_prev && (r_shadow == r_result);
            if (w_capture) begin
                if (w_face_ok) begin
                    r_result     <= r_shadow;
                    r_roll_count <= r_roll_count + 8'd1;
                    r_score      <= w_sum[SCORE_W] ? c_SCORE_MAX : w_sum[SCORE_W-1:0];
                    r_have_prev  <= 1'b1;
                end else begin
                    r_bad <= 1'b1;
                end
            end
        end
    end

`ifdef DICE_HIST_EN
    logic [6:1][7:0] r_hist;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hist <= '0;
        end else begin
            for (int i = 1; i <= 6; i++) begin
                if (w_capture && (r_shadow == i[2:0]) && (r_hist[i] != 8'hFF)) begin
                    r_hist[i] <= r_hist[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_hist = 8'd0;
        case (hist_sel)
            3'd1:    w_hist = r_hist[1];
            3'd2:    w_hist = r_hist[2];
            3'd3:    w_hist = r_hist[3];
            3'd4:    w_hist = r_hist[4];
            3'd5:    w_hist = r_hist[5];
            3'd6:    w_hist = r_hist[6];
            default: w_hist = 8'd0;
        endcase
    end
`else
    logic w_unused_hist_sel;

    assign w_unused_hist_sel = ^hist_sel;
    assign w_hist            = 8'd0;
`endif

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign rolling      = r_rolling;
    assign score        = r_score;
    assign roll_count   = r_roll_count;
    assign double_flag  = r_double;
    assign bad_throw    = r_bad;
    assign hist_count   = w_hist;

endmodule
`default_nettype wire
